shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_pkg.sv | 12 +
 rtl/barrel_shifter.sv | 18 +
 rtl/shift_arbiter.sv | 115 +++++++++++
 tb/tb_shift_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: FSM state encoding and default sizes.
package shift_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational logical shifter with zero fill; dir=0 shifts left, dir=1 shifts right.
module barrel_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int AW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    shift_amt,
    input  logic             dir,
    output logic [WIDTH-1:0] data_out
);

    always_comb begin
        data_out = dir ? (data_in >> shift_amt) : (data_in << shift_amt);
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NUM_REQ requesters,
// with a single registered result slot drained by a valid/ready consumer.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    localparam int AW     = $clog2(WIDTH),
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ*AW-1:0]  req_amt,
    input  logic [NUM_REQ-1:0]     req_dir,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IW-1:0]          out_id,
    output logic [15:0]            op_count
);

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    cand;
    logic             any_valid;
    logic             can_accept;
    logic             transfer;
    logic [WIDTH-1:0] sel_data;
    logic [AW-1:0]    sel_amt;
    logic             sel_dir;
    logic [WIDTH-1:0] shift_res;
    logic [WIDTH-1:0] out_data_q;
    logic [IW-1:0]    out_id_q;
    logic [15:0]      op_count_q;

    // Scan downward so the candidate closest to rr_ptr is the one left standing.
    always_comb begin
        grant_idx = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                grant_idx = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign can_accept = (state_q == IDLE) || out_ready;
    assign transfer   = !rst && can_accept && any_valid;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_data = req_data[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_amt  = req_amt[int'(grant_idx)*AW +: AW];
    assign sel_dir  = req_dir[grant_idx];

    barrel_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .data_in  (sel_data),
        .shift_amt(sel_amt),
        .dir      (sel_dir),
        .data_out (shift_res)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: if (transfer) state_d = HOLD;
            HOLD: if (out_ready) state_d = transfer ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
        if (transfer) begin
            rr_ptr_d = IW'((int'(grant_idx) + 1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (transfer) begin
                out_data_q <= shift_res;
                out_id_q   <= grant_idx;
            end
            if (state_q == HOLD && out_ready) begin
                op_count_q <= op_count_q + 16'd1;
            end
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_shift_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 3;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_data;
    logic [N*AW-1:0] req_amt;
    logic [N-1:0]    req_dir;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [IW-1:0]   out_id;
    logic [15:0]     op_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the result slot
    bit m_full;
    int m_data, m_id, m_ptr, m_cnt;

    always #5 clk = ~clk;

    shift_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_amt  (req_amt),
        .req_dir  (req_dir),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_id   (out_id),
        .op_count (op_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int shift_ref(input int d, input int a, input bit right);
        if (right) return d / (2 ** a);
        return (d * (2 ** a)) % (2 ** W);
    endfunction

    // One clock: check grant before the edge, advance the model, check registered outputs after.
    task automatic cycle();
        int  g;
        bit  found;
        bit  can;
        int  exp_rdy;
        found = 0;
        g     = 0;
        can   = 0;
        @(negedge clk);
        if (!rst) begin
            can = !m_full || out_ready;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!found && req_valid[j]) begin
                    found = 1;
                    g     = j;
                end
            end
        end
        exp_rdy = (!rst && can && found) ? (1 << g) : 0;
        chk("req_ready", 32'(req_ready), exp_rdy);
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_full && out_ready) m_cnt = (m_cnt + 1) % 65536;
            if (exp_rdy != 0) begin
                m_data = shift_ref(int'(req_data[g*W +: W]), int'(req_amt[g*AW +: AW]), req_dir[g]);
                m_id   = g;
                m_ptr  = (g + 1) % N;
                m_full = 1;
            end else if (out_ready) begin
                m_full = 0;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("out_data",  32'(out_data),  m_data);
        chk("out_id",    32'(out_id),    m_id);
        chk("op_count",  32'(op_count),  m_cnt);
    endtask

    task automatic set_req(input int i, input logic [W-1:0] d, input logic [AW-1:0] a, input logic dr);
        req_data[i*W +: W]   = d;
        req_amt[i*AW +: AW]  = a;
        req_dir[i]           = dr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] held;
        m_full = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
        rst = 1'b1; req_valid = '0; req_data = '0; req_amt = '0; req_dir = '0; out_ready = 1'b1;
        #1;
        do_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(op_count), 0);

        // Single left shift from requester 0
        out_ready = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 8'b10101010, 3'd3, 1'b0);
        cycle();
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data", 32'(out_data), 32'h50);
        chk("single_id", 32'(out_id), 0);

        // Right shift and max left shift from requester 1
        out_ready = 1'b1;
        req_valid = 4'b0010;
        set_req(1, 8'b10101010, 3'd3, 1'b1);
        cycle();
        chk("right_data", 32'(out_data), 32'h15);
        chk("right_id", 32'(out_id), 1);
        set_req(1, 8'b00000001, 3'd7, 1'b0);
        cycle();
        chk("left7_data", 32'(out_data), 32'h80);
        req_valid = '0;
        cycle();
        chk("drain_valid", 32'(out_valid), 0);

        // Round-robin with everyone requesting
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, W'(i + 1), 3'(i), 1'b0);
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_seq", 32'(out_id), k % N);
        end

        // Backpressure: grants stop and the result holds
        out_ready = 1'b0;
        held = W'(m_data);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_hold", 32'(out_data), 32'(held));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume", 32'(req_ready != 0), 1);
        cycle();

        // Reset while holding a result
        out_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rsthold_valid", 32'(out_valid), 0);
        chk("rsthold_count", 32'(op_count), 0);
        #1;
        chk("rsthold_grant", 32'(req_ready), 1);
        out_ready = 1'b1;
        cycle();

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            req_valid = N'($urandom);
            req_data  = ($urandom);
            req_amt   = (N*AW)'($urandom);
            req_dir   = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            cycle();
        end
        rst = 1'b0;

        // Counter wrap: 65537 deliveries
        do_reset();
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 65538; k++) cycle();
        chk("count_wrap", 32'(op_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
